// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: opcodes, request kinds,
// encoder FSM states and the legal immediate ranges of each format.
package instr_pkg;

   localparam logic [6:0] OP_ALI    = 7'b0010011;
   localparam logic [6:0] OP_MEM_WR = 7'b0100011;
   localparam logic [6:0] OP_MEM_RD = 7'b0000011;
   localparam logic [6:0] OP_BR     = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      KIND_R   = 3'd0,
      KIND_I   = 3'd1,
      KIND_S   = 3'd2,
      KIND_B   = 3'd3,
      KIND_U   = 3'd4,
      KIND_J   = 3'd5,
      KIND_LI  = 3'd6,
      KIND_RSV = 3'd7
   } kind_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_OUT       = 2'd1,
      ST_LI_SECOND = 2'd2
   } state_e;

   // Signed immediate limits (inclusive) per format.
   localparam int signed IMM12_MIN = -2048;
   localparam int signed IMM12_MAX = 2047;
   localparam int signed IMM13_MIN = -4096;
   localparam int signed IMM13_MAX = 4094;
   localparam int signed IMM21_MIN = -1048576;
   localparam int signed IMM21_MAX = 1048574;
   localparam logic [31:0] SHAMT_MAX = 32'd31;

   // Shift-immediates reuse the I format but carry funct7 and a 5-bit shamt.
   function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] f3);
      return (op == OP_ALI) && ((f3 == 3'b001) || (f3 == 3'b101));
   endfunction

   // Opcodes whose immediate is decoded from the I-format field.
   function automatic logic is_i_imm_op(input logic [6:0] op);
      return (op == OP_ALI) || (op == OP_MEM_RD) || (op == OP_JALR);
   endfunction

   // Opcodes whose immediate is decoded from the U-format field.
   function automatic logic is_u_imm_op(input logic [6:0] op);
      return (op == OP_LUI) || (op == OP_AUIPC);
   endfunction

   // Opcodes using the S, B and J immediate layouts respectively.
   function automatic logic [2:0] sbj_class(input logic [6:0] op);
      return {op == OP_MEM_WR, op == OP_BR, op == OP_JAL};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds one RV32I word for a single-word kind
// and flags immediates that the chosen format cannot represent exactly.
module instr_pack
   import instr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       i_kind,
   input  logic [6:0]       i_opcode,
   input  logic [2:0]       i_func3,
   input  logic [6:0]       i_func7,
   input  logic [4:0]       i_rd,
   input  logic [4:0]       i_rs1,
   input  logic [4:0]       i_rs2,
   input  logic [WIDTH-1:0] i_imm,
   output logic [WIDTH-1:0] o_instr,
   output logic             o_err
);

   logic signed [WIDTH-1:0] w_simm;

   assign w_simm = signed'(i_imm);

   // Field packing and range check selected by request kind.
   always_comb begin
      o_instr = '0;
      o_err   = 1'b0;
      case (kind_e'(i_kind))
         KIND_R: begin
            o_instr = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
         end
         KIND_I: begin
            if (is_shift_imm(i_opcode, i_func3)) begin
               o_instr = {i_func7, i_imm[4:0], i_rs1, i_func3, i_rd, i_opcode};
               o_err   = (i_imm > SHAMT_MAX);
            end else begin
               o_instr = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
               o_err   = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
            end
         end
         KIND_S: begin
            o_instr = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
            o_err   = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
         end
         KIND_B: begin
            o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                       i_imm[4:1], i_imm[11], i_opcode};
            o_err   = (w_simm < IMM13_MIN) || (w_simm > IMM13_MAX) || i_imm[0];
         end
         KIND_U: begin
            o_instr = {i_imm[31:12], i_rd, i_opcode};
            o_err   = (i_imm[11:0] != 12'd0);
         end
         KIND_J: begin
            o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            o_err   = (w_simm < IMM21_MIN) || (w_simm > IMM21_MAX) || i_imm[0];
         end
         KIND_RSV: begin
            o_instr = '0;
            o_err   = 1'b1;
         end
         default: begin
            // LI is expanded by the encoder itself, never packed here.
            o_instr = '0;
            o_err   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field/immediate requests over valid/ready,
// expands LI into LUI/ADDI when needed and streams words out through a
// single output register with latency 1.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_kind,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_func3,
   input  logic [6:0]       in_func7,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic             out_last,
   output logic             out_err
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_instr;
   logic             r_last;
   logic             r_err;
   logic [WIDTH-1:0] r_addi;

   logic [WIDTH-1:0] w_pack_instr;
   logic             w_pack_err;
   logic             w_accept;
   logic             w_hs;
   logic             w_is_li;
   logic [19:0]      w_li_hi;
   logic [11:0]      w_li_lo;
   logic             w_li_two;
   logic [WIDTH-1:0] w_lui;
   logic [WIDTH-1:0] w_addi_x0;
   logic [WIDTH-1:0] w_addi_rd;
   logic [WIDTH-1:0] w_first_instr;
   logic             w_first_err;

   instr_pack #(.WIDTH(WIDTH)) u_pack (
      .i_kind   (in_kind),
      .i_opcode (in_opcode),
      .i_func3  (in_func3),
      .i_func7  (in_func7),
      .i_rd     (in_rd),
      .i_rs1    (in_rs1),
      .i_rs2    (in_rs2),
      .i_imm    (in_imm),
      .o_instr  (w_pack_instr),
      .o_err    (w_pack_err)
   );

   // hi rounds up when lo is negative so that LUI + sext(ADDI) rebuilds imm;
   // the 20-bit sum wraps naturally (0x7FFFF800 -> hi 0x80000).
   assign w_li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
   assign w_li_lo   = in_imm[11:0];
   assign w_is_li   = (in_kind == KIND_LI);
   assign w_li_two  = w_is_li && (w_li_hi != 20'd0) && (w_li_lo != 12'd0);
   assign w_lui     = {w_li_hi, in_rd, OP_LUI};
   assign w_addi_x0 = {w_li_lo, 5'd0, 3'b000, in_rd, OP_ALI};
   assign w_addi_rd = {w_li_lo, in_rd, 3'b000, in_rd, OP_ALI};

   assign w_first_instr = !w_is_li            ? w_pack_instr :
                          (w_li_hi == 20'd0)  ? w_addi_x0    : w_lui;
   assign w_first_err   = w_is_li ? 1'b0 : w_pack_err;

   assign out_valid = (r_state != ST_IDLE);
   assign in_ready  = (r_state != ST_LI_SECOND) && (!out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_hs      = out_valid && out_ready;
   assign out_instr = r_instr;
   assign out_last  = r_last;
   assign out_err   = r_err;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: new accepts take priority, LI_SECOND drains its staged ADDI.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_OUT: begin
            if (w_accept) begin
               w_state_nxt = w_li_two ? ST_LI_SECOND : ST_OUT;
            end else if (w_hs) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LI_SECOND: begin
            if (w_hs) begin
               w_state_nxt = ST_OUT;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output register and staged ADDI; held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= '0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
         r_addi  <= '0;
      end else if (w_accept) begin
         r_instr <= w_first_instr;
         r_last  <= !w_li_two;
         r_err   <= w_first_err;
         r_addi  <= w_addi_rd;
      end else if ((r_state == ST_LI_SECOND) && w_hs) begin
         r_instr <= r_addi;
         r_last  <= 1'b1;
         r_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of single-word requests with
// hand-encoded words, plus LI stall, wrap, throughput and mid-LI reset runs.
module tb_instr_encoder;
   import instr_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_kind;
   logic [6:0]  in_opcode;
   logic [2:0]  in_func3;
   logic [6:0]  in_func7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  kind;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   localparam int NV = 21;
   vec_t tv[NV];

   instr_encoder #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_opcode (in_opcode),
      .in_func3  (in_func3),
      .in_func7  (in_func7),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] k, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] exp, input logic err);
      vec_t v;
      v.kind = k; v.op = op; v.f3 = f3; v.f7 = f7;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.exp = exp; v.err = err;
      return v;
   endfunction

   // Reference immediate decoder (the core's immediate generator behaviour).
   function automatic logic [31:0] dec_imm(input logic [31:0] w);
      logic [31:0] r;
      if (is_u_imm_op(w[6:0]))
         r = {w[31:12], 12'd0};
      else if (w[6:0] == OP_JAL)
         r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      else if (w[6:0] == OP_BR)
         r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      else if (w[6:0] == OP_MEM_WR)
         r = {{20{w[31]}}, w[31:25], w[11:7]};
      else if (is_shift_imm(w[6:0], w[14:12]))
         r = {27'd0, w[24:20]};
      else
         r = {{20{w[31]}}, w[31:20]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_kind = v.kind; in_opcode = v.op; in_func3 = v.f3; in_func7 = v.f7;
      in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v);
      int n;
      n = 0;
      drive(v);
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] lui_w;
      int          nvalid;

      tv[0]  = mk(KIND_I,   7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF, 32'hFFF30293, 1'b0);
      tv[1]  = mk(KIND_B,   7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
      tv[2]  = mk(KIND_B,   7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF9, 32'hFE208CE3, 1'b1);
      tv[3]  = mk(KIND_I,   7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'h00000800, 32'h80030293, 1'b1);
      tv[4]  = mk(KIND_LI,  7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000005, 32'h00500093, 1'b0);
      tv[5]  = mk(KIND_R,   7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'h00000000, 32'h405201B3, 1'b0);
      tv[6]  = mk(KIND_S,   7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 32'hFE512E23, 1'b0);
      tv[7]  = mk(KIND_S,   7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFFF7FF, 32'h7E512FA3, 1'b1);
      tv[8]  = mk(KIND_U,   7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE3B7, 1'b0);
      tv[9]  = mk(KIND_U,   7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'h00001001, 32'h000013B7, 1'b1);
      tv[10] = mk(KIND_J,   7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
      tv[11] = mk(KIND_J,   7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0);
      tv[12] = mk(KIND_J,   7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, 1'b1);
      tv[13] = mk(KIND_I,   7'h13, 3'd1, 7'h00, 5'd5, 5'd6, 5'd0, 32'd31,        32'h01F31293, 1'b0);
      tv[14] = mk(KIND_I,   7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3,         32'h40335293, 1'b0);
      tv[15] = mk(KIND_I,   7'h13, 3'd1, 7'h00, 5'd5, 5'd6, 5'd0, 32'd32,        32'h00031293, 1'b1);
      tv[16] = mk(KIND_RSV, 7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'h00000000, 32'h00000000, 1'b1);
      tv[17] = mk(KIND_LI,  7'h00, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137, 1'b0);
      tv[18] = mk(KIND_LI,  7'h00, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000193, 1'b0);
      tv[19] = mk(KIND_B,   7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00001000, 32'h80208063, 1'b1);
      tv[20] = mk(KIND_I,   7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'hFFFFF800, 32'h80030293, 1'b0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(tv[0]);
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_last",  {31'd0, out_last}, 32'd0);
      chk("rst_err",   {31'd0, out_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("idle_ready", {31'd0, in_ready}, 32'd1);

      // Table: one request at a time, result one cycle after accept.
      for (int i = 0; i < NV; i++) begin
         send(tv[i]);
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_instr", i), out_instr, tv[i].exp);
         chk($sformatf("v%0d_last", i),  {31'd0, out_last}, 32'd1);
         chk($sformatf("v%0d_err", i),   {31'd0, out_err}, {31'd0, tv[i].err});
         if (!tv[i].err && tv[i].kind != KIND_R)
            chk($sformatf("v%0d_roundtrip", i), dec_imm(out_instr), tv[i].imm);
      end
      @(posedge clk); #1;
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Throughput: ten back-to-back requests, one word per cycle.
      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         drive(tv[k]);
         in_valid = 1'b1;
         chk($sformatf("tp%0d_ready", k), {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         if (out_valid) nvalid++;
         chk($sformatf("tp%0d_instr", k), out_instr, tv[k].exp);
      end
      in_valid = 1'b0;
      chk("tp_count", nvalid, 32'd10);
      @(posedge clk); #1;
      chk("tp_drain", {31'd0, out_valid}, 32'd0);

      // LI two-word with the LUI stalled for three cycles.
      out_ready = 1'b0;
      send(mk(KIND_LI, 7'h00, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 32'h0, 1'b0));
      chk("li_lui",       out_instr, 32'h12346537);
      chk("li_lui_last",  {31'd0, out_last}, 32'd0);
      chk("li_lui_ready", {31'd0, in_ready}, 32'd0);
      lui_w = out_instr;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("li_stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("li_stall%0d_instr", c), out_instr, 32'h12346537);
         chk($sformatf("li_stall%0d_ready", c), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("li_addi",      out_instr, 32'h0FFF50513 & 32'hFFFFFFFF);
      chk("li_addi_last", {31'd0, out_last}, 32'd1);
      chk("li_addi_err",  {31'd0, out_err}, 32'd0);
      chk("li_roundtrip", dec_imm(lui_w) + dec_imm(out_instr), 32'h12345FFF);
      @(posedge clk); #1;
      chk("li_drain", {31'd0, out_valid}, 32'd0);

      // LI wrap: hi carries into bit 31.
      send(mk(KIND_LI, 7'h00, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'h7FFFF800, 32'h0, 1'b0));
      chk("wrap_lui",      out_instr, 32'h80000237);
      chk("wrap_lui_last", {31'd0, out_last}, 32'd0);
      lui_w = out_instr;
      @(posedge clk); #1;
      chk("wrap_addi",      out_instr, 32'h80020213);
      chk("wrap_addi_last", {31'd0, out_last}, 32'd1);
      chk("wrap_roundtrip", dec_imm(lui_w) + dec_imm(out_instr), 32'h7FFFF800);
      @(posedge clk); #1;

      // Reset while the LUI is held: ADDI must never appear.
      out_ready = 1'b0;
      send(mk(KIND_LI, 7'h00, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 32'h0, 1'b0));
      chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_instr", out_instr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mr_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("mr_noaddi%0d", c), {31'd0, out_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator: packs instruction fields plus a full 32-bit immediate into a legal RV32I instruction word.
- Also expands the LI pseudo-op into a LUI/ADDI sequence.
- Sits between the test-program / boot-ROM loader and instruction memory; streams words out over a valid/ready handshake.
- Every emitted word must decode back, through the immediate generator, to the requested immediate.

Parameters:
- WIDTH, 32, instruction/immediate width (only 32 supported)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_kind  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5, LI=6, 7=reserved
- in_opcode  in  7  opcode field (ignored for LI)
- in_func3  in  3  funct3 (R/I/S/B)
- in_func7  in  7  funct7 (R; also shift-immediates)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate as the signed byte value the decoder must reproduce
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_last  out  1  last word of this request (0 only on the LUI of a two-word LI)
- out_err  out  1  immediate out of range/misaligned, or reserved kind; word still emitted

Behaviour:
- Reset (async, any state): out_valid=0, out_instr=0, out_last=0, out_err=0, state=IDLE, any pending ADDI discarded.
- Handshake:
  - in_ready = (state != LI_SECOND) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - out_instr/out_last/out_err are registered and appear the cycle after accept (latency 1).
  - Output held stable while out_valid && !out_ready.
  - Back-to-back acceptance gives one word per cycle.
- States:
  - IDLE: output register empty.
  - OUT: word held.
  - LI_SECOND: LUI held; ADDI is staged internally.
  - Transitions:
    - IDLE/OUT→OUT on accept of a single-word request.
    - →LI_SECOND on accept of a two-word LI.
    - LI_SECOND→OUT when the LUI handshakes; the staged ADDI is loaded with out_last=1.
    - OUT→IDLE on handshake with no new accept.
- Encoding (fields truncated to format width):
  - R: func7|rs2|rs1|func3|rd|opcode.
  - I: imm[11:0]|rs1|func3|rd|opcode.
  - I with opcode 0010011 and func3 001/101: func7|imm[4:0]|rs1|func3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|func3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- out_err rules:
  - I/S: imm outside [-2048, 2047].
  - Shift-immediate: imm outside [0, 31].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0]≠0.
  - Kind 7: out_instr=0.
  - R and LI never set out_err.
- LI expansion:
  - hi = (imm + 0x800)[31:12], mod 2^32; lo = imm[11:0].
  - hi==0: single ADDI rd,x0,lo.
  - lo==0: single LUI rd,hi.
  - Otherwise: LUI rd,hi then ADDI rd,rd,lo.
  - Wrap case: imm=0x7FFFF800 gives hi=0x80000, lo=0x800; the pair is legal.

Decomposition:
- Shared package (instr_pkg): opcode localparams (ALI, MEM_WR, MEM_RD, BR, JALR, JAL, LUI, AUIPC), in_kind enum, and encoding range limits.
- The imm_gen module already in the codebase is reused as a package consumer.
- One natural sub-module: instr_pack, combinational field packing plus range check. instr_encoder keeps the FSM, LI split and output register.

Test Plan:
- I-type: kind=I, opcode=0010011, func3=000, rd=5, rs1=6, imm=0xFFFFFFFF → out_instr=0xFFF30293, out_last=1, out_err=0, one cycle after accept.
- LI two-word: kind=LI, rd=10, imm=0x12345FFF → 0x12346537 (out_last=0), then 0xFFF50513 (out_last=1). Hold out_ready=0 for 3 cycles on the first word: word stable and in_ready=0 throughout.
- LI single-word: kind=LI, rd=1, imm=5 → single 0x00500093, out_last=1.
- B-type: opcode=1100011, func3=000, rs1=1, rs2=2, imm=-8 → 0xFE208CE3. Same request with imm=-7 → out_err=1.
- Range error and throughput: kind=I imm=2048 → out_err=1. Ten back-to-back requests with out_ready=1 → ten words in ten consecutive cycles. Every legal word is round-tripped through imm_gen and matches in_imm.
- Reset mid-LI: assert rst while in LI_SECOND → out_valid=0 immediately, ADDI never emitted; in_ready=1 the first cycle after rst deasserts.
